// File: rtl/rr_mux16_sched.sv
// Round-robin scheduler for a shared 16:1 W-bit mux path with bounded grant length.
// Registers the selected requester word together with a valid flag.
module rr_mux16_sched #(
   parameter int unsigned W        = 2,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [15:0]     req,
   input  logic [16*W-1:0] data_in,
   output logic [15:0]     gnt,
   output logic [3:0]      sel,
   output logic            busy,
   output logic [W-1:0]    y,
   output logic            y_valid
);

   localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
   localparam logic [CntW-1:0] HoldMax = CntW'(MAX_HOLD);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [3:0]      ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     gnt_q, gnt_d;
   logic [3:0]      sel_q, sel_d;
   logic [W-1:0]    y_q, y_d;
   logic            y_valid_q, y_valid_d;
   logic [3:0]      winner;

   // Scan offsets from high to low so the closest request after ptr wins last.
   always_comb begin
      logic [3:0] idx;
      winner = 4'd0;
      for (int unsigned k = 16; k > 0; k--) begin
         idx = ptr_q + 4'(k - 1);
         if (req[idx]) winner = idx;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      y_d       = y_q;
      y_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            gnt_d = 16'd0;
            if (|req) begin
               sel_d   = winner;
               gnt_d   = 16'd1 << winner;
               cnt_d   = CntW'(1);
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (req[sel_q]) begin
               y_d       = data_in[sel_q*W +: W];
               y_valid_d = 1'b1;
            end
            // A drop coinciding with hold expiry is still a single release.
            if (!req[sel_q] || cnt_q == HoldMax) begin
               state_d = StIdle;
               gnt_d   = 16'd0;
               ptr_d   = sel_q + 4'd1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= 4'd0;
         cnt_q     <= '0;
         gnt_q     <= 16'd0;
         sel_q     <= 4'd0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign busy    = (state_q == StGrant);
   assign y       = y_q;
   assign y_valid = y_valid_q;

endmodule
